branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver_pkg.sv | 29 ++
 rtl/branch_resolver_pred_queue.sv | 64 ++++++
 rtl/branch_resolver.sv | 163 ++++++++++++++++
 tb/tb_branch_resolver.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// ============================================================================
// Module : branch_resolver_pkg
// Shared FSM encoding, default sizes and saturating counter helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package branch_resolver_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int c_DEF_ADDRESS_WIDTH = 22;
  localparam int c_DEF_GHR_SIZE      = 8;
  localparam int c_DEF_QUEUE_DEPTH   = 4;
  localparam int c_DEF_FLUSH_CYCLES  = 2;

  localparam int                     c_COUNT_WIDTH = 16;
  localparam logic [c_COUNT_WIDTH-1:0] c_COUNT_MAX = '1;

  function automatic logic [c_COUNT_WIDTH-1:0] sat_inc(input logic [c_COUNT_WIDTH-1:0] v);
    return (v == c_COUNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_resolver_pred_queue.sv
// ============================================================================
// Module : pred_queue
// Synchronous FIFO of in-flight predictions with clear; pop of oldest entry.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pred_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == c_CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A full queue still accepts a push when the oldest entry leaves this cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge i_Clk) begin
    if (w_do_push && !i_clear && !i_Reset) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_resolver.sv
// ============================================================================
// Module : branch_resolver
// Resolves BEQ/BNE in EX against queued predictions; redirects and flushes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int ADDRESS_WIDTH = c_DEF_ADDRESS_WIDTH,
  parameter int GHR_SIZE      = c_DEF_GHR_SIZE,
  parameter int QUEUE_DEPTH   = c_DEF_QUEUE_DEPTH,
  parameter int FLUSH_CYCLES  = c_DEF_FLUSH_CYCLES
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_IF_push,
  input  logic [GHR_SIZE-1:0]      i_IF_pc,
  input  logic                     i_IF_prediction,
  input  logic                     i_EX_branch,
  input  logic                     i_EX_zero,
  input  logic                     i_EX_bne,
  input  logic [ADDRESS_WIDTH-1:0] i_EX_target,
  input  logic [ADDRESS_WIDTH-1:0] i_EX_pc_plus4,
  output logic                     o_ALU_outcome,
  output logic [GHR_SIZE-1:0]      o_ALU_pc,
  output logic                     o_ALU_isbranch,
  output logic                     o_ALU_prediction,
  output logic                     o_Redirect_valid,
  output logic [ADDRESS_WIDTH-1:0] o_Redirect_pc,
  output logic                     o_Flush,
  output logic [c_COUNT_WIDTH-1:0] o_Branch_count,
  output logic [c_COUNT_WIDTH-1:0] o_Mispredict_count,
  output logic                     o_Underflow
);

  localparam int c_FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_FC_W-1:0]   r_flush_cnt;
  logic [c_FC_W-1:0]   w_flush_cnt_nxt;

  logic                w_run;
  logic                w_accept;
  logic                w_push;
  logic                w_taken;
  logic                w_pred;
  logic [GHR_SIZE-1:0] w_pc;
  logic                w_mispredict;
  logic [GHR_SIZE:0]   w_q_data;
  logic                w_q_full;
  logic                w_q_empty;

  logic                     r_alu_outcome;
  logic [GHR_SIZE-1:0]      r_alu_pc;
  logic                     r_alu_isbranch;
  logic                     r_alu_prediction;
  logic                     r_redirect_valid;
  logic [ADDRESS_WIDTH-1:0] r_redirect_pc;
  logic [c_COUNT_WIDTH-1:0] r_branch_count;
  logic [c_COUNT_WIDTH-1:0] r_mispredict_count;
  logic                     r_underflow;

  assign w_run        = (r_state == RUN);
  assign w_accept     = i_EX_branch && w_run;
  assign w_push       = i_IF_push && w_run && (!w_q_full || w_accept);
  assign w_taken      = i_EX_bne ? !i_EX_zero : i_EX_zero;
  // An empty-queue pop resolves as a not-taken prediction from index 0.
  assign w_pred       = w_q_empty ? 1'b0 : w_q_data[0];
  assign w_pc         = w_q_empty ? '0 : w_q_data[GHR_SIZE:1];
  assign w_mispredict = w_accept && (w_taken != w_pred);

  pred_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (GHR_SIZE + 1)
  ) u_queue (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_clear (w_mispredict),
    .i_push  (w_push),
    .i_pop   (w_accept),
    .i_data  ({i_IF_pc, i_IF_prediction}),
    .o_data  (w_q_data),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    o_Flush         = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mispredict) begin
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = '0;
        end
      end
      FLUSH: begin
        o_Flush = 1'b1;
        if (r_flush_cnt == c_FC_W'(FLUSH_CYCLES - 1)) begin
          w_state_nxt = RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt + 1'b1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_alu_outcome      <= 1'b0;
      r_alu_pc           <= '0;
      r_alu_isbranch     <= 1'b0;
      r_alu_prediction   <= 1'b0;
      r_redirect_valid   <= 1'b0;
      r_redirect_pc      <= '0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
      r_underflow        <= 1'b0;
    end else begin
      r_alu_isbranch   <= w_accept;
      r_redirect_valid <= w_mispredict;
      if (w_accept) begin
        r_alu_outcome    <= w_taken;
        r_alu_pc         <= w_pc;
        r_alu_prediction <= w_pred;
        r_branch_count   <= sat_inc(r_branch_count);
        if (w_q_empty) r_underflow <= 1'b1;
      end
      if (w_mispredict) begin
        r_redirect_pc      <= w_taken ? i_EX_target : i_EX_pc_plus4;
        r_mispredict_count <= sat_inc(r_mispredict_count);
      end
    end
  end

  assign o_ALU_outcome      = r_alu_outcome;
  assign o_ALU_pc           = r_alu_pc;
  assign o_ALU_isbranch     = r_alu_isbranch;
  assign o_ALU_prediction   = r_alu_prediction;
  assign o_Redirect_valid   = r_redirect_valid;
  assign o_Redirect_pc      = r_redirect_pc;
  assign o_Branch_count     = r_branch_count;
  assign o_Mispredict_count = r_mispredict_count;
  assign o_Underflow        = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolver.sv
// ============================================================================
// Module : tb_branch_resolver
// Directed vector table plus hand sequences for reset, full queue, saturation.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolver;

  logic        clk;
  logic        rst;
  logic        if_push;
  logic [7:0]  if_pc;
  logic        if_pred;
  logic        ex_branch;
  logic        ex_zero;
  logic        ex_bne;
  logic [21:0] ex_target;
  logic [21:0] ex_pc4;
  logic        alu_outcome;
  logic [7:0]  alu_pc;
  logic        alu_isbranch;
  logic        alu_pred;
  logic        redir_valid;
  logic [21:0] redir_pc;
  logic        flush;
  logic [15:0] bcount;
  logic [15:0] mcount;
  logic        underflow;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        isb;
    logic        outc;
    logic [7:0]  pc;
    logic        pred;
    logic        rv;
    logic [21:0] rpc;
    logic        flush;
    logic [15:0] bc;
    logic [15:0] mc;
    logic        uf;
  } obs_t;

  typedef struct {
    string       name;
    logic        push;
    logic [7:0]  ipc;
    logic        ipred;
    logic        br;
    logic        zero;
    logic        bne;
    logic [21:0] tgt;
    logic [21:0] pc4;
    obs_t        exp;
  } vec_t;

  vec_t tbl[$];

  branch_resolver dut (
    .i_Clk              (clk),
    .i_Reset            (rst),
    .i_IF_push          (if_push),
    .i_IF_pc            (if_pc),
    .i_IF_prediction    (if_pred),
    .i_EX_branch        (ex_branch),
    .i_EX_zero          (ex_zero),
    .i_EX_bne           (ex_bne),
    .i_EX_target        (ex_target),
    .i_EX_pc_plus4      (ex_pc4),
    .o_ALU_outcome      (alu_outcome),
    .o_ALU_pc           (alu_pc),
    .o_ALU_isbranch     (alu_isbranch),
    .o_ALU_prediction   (alu_pred),
    .o_Redirect_valid   (redir_valid),
    .o_Redirect_pc      (redir_pc),
    .o_Flush            (flush),
    .o_Branch_count     (bcount),
    .o_Mispredict_count (mcount),
    .o_Underflow        (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk_obs(input logic isb, input logic outc, input logic [7:0] pc,
                                  input logic pred, input logic rv, input logic [21:0] rpc,
                                  input logic fl, input logic [15:0] bc, input logic [15:0] mc,
                                  input logic uf);
    obs_t o;
    o = '{isb: isb, outc: outc, pc: pc, pred: pred, rv: rv, rpc: rpc, flush: fl, bc: bc, mc: mc, uf: uf};
    return o;
  endfunction

  function automatic vec_t mk_vec(input string name, input logic push, input logic [7:0] ipc,
                                  input logic ipred, input logic br, input logic zero, input logic bne,
                                  input logic [21:0] tgt, input logic [21:0] pc4, input obs_t exp);
    vec_t v;
    v.name = name; v.push = push; v.ipc = ipc; v.ipred = ipred; v.br = br;
    v.zero = zero; v.bne = bne; v.tgt = tgt; v.pc4 = pc4; v.exp = exp;
    return v;
  endfunction

  // Quiet cycle: no push, no branch; only the expected outputs matter.
  function automatic vec_t idle(input string name, input obs_t exp);
    return mk_vec(name, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 22'h0, exp);
  endfunction

  task automatic check_obs(input string name, input obs_t exp_in);
    obs_t act;
    obs_t exp;
    act = '{isb: alu_isbranch, outc: alu_outcome, pc: alu_pc, pred: alu_pred, rv: redir_valid,
            rpc: redir_pc, flush: flush, bc: bcount, mc: mcount, uf: underflow};
    exp = exp_in;
    if (!exp.isb) begin
      act.outc = 1'b0; act.pc = '0; act.pred = 1'b0;
      exp.outc = 1'b0; exp.pc = '0; exp.pred = 1'b0;
    end
    if (!exp.rv) begin
      act.rpc = '0;
      exp.rpc = '0;
    end
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got isb=%0b out=%0b pc=%h pred=%0b rv=%0b rpc=%h flush=%0b bc=%h mc=%h uf=%0b ; want isb=%0b out=%0b pc=%h pred=%0b rv=%0b rpc=%h flush=%0b bc=%h mc=%h uf=%0b",
               name, act.isb, act.outc, act.pc, act.pred, act.rv, act.rpc, act.flush, act.bc, act.mc, act.uf,
               exp.isb, exp.outc, exp.pc, exp.pred, exp.rv, exp.rpc, exp.flush, exp.bc, exp.mc, exp.uf);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    rst       = 1'b0;
    if_push   = v.push;
    if_pc     = v.ipc;
    if_pred   = v.ipred;
    ex_branch = v.br;
    ex_zero   = v.zero;
    ex_bne    = v.bne;
    ex_target = v.tgt;
    ex_pc4    = v.pc4;
    @(posedge clk);
    #1;
    check_obs(v.name, v.exp);
  endtask

  // Asserts reset for one edge while leaving the other inputs as they were;
  // the next apply_vec releases it so the very next edge is a live cycle.
  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_obs(name, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout ; want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_push = 1'b0; if_pc = '0; if_pred = 1'b0; ex_branch = 1'b0;
    ex_zero = 1'b0; ex_bne = 1'b0; ex_target = '0; ex_pc4 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_obs("reset_state", '0);

    // name, push, pc, pred, br, zero, bne, target, pc+4, expected outputs after the edge
    tbl.push_back(idle("idle0", '0));
    tbl.push_back(mk_vec("push10", 1, 8'h10, 1, 0, 0, 0, 22'h0, 22'h0, mk_obs(0,0,8'h00,0,0,22'h0,0,16'd0,16'd0,0)));
    tbl.push_back(mk_vec("beq_correct", 0, 8'h00, 0, 1, 1, 0, 22'h200, 22'h004, mk_obs(1,1,8'h10,1,0,22'h0,0,16'd1,16'd0,0)));
    tbl.push_back(idle("strobe_drop", mk_obs(0,0,8'h00,0,0,22'h0,0,16'd1,16'd0,0)));
    tbl.push_back(mk_vec("push22", 1, 8'h22, 0, 0, 0, 0, 22'h0, 22'h0, mk_obs(0,0,8'h00,0,0,22'h0,0,16'd1,16'd0,0)));
    tbl.push_back(mk_vec("bne_mispredict", 0, 8'h00, 0, 1, 0, 1, 22'h100, 22'h02C, mk_obs(1,1,8'h22,0,1,22'h100,1,16'd2,16'd1,0)));
    tbl.push_back(idle("flush_2nd", mk_obs(0,0,8'h00,0,0,22'h0,1,16'd2,16'd1,0)));
    tbl.push_back(idle("flush_end", mk_obs(0,0,8'h00,0,0,22'h0,0,16'd2,16'd1,0)));
    tbl.push_back(mk_vec("empty_pop", 0, 8'h00, 0, 1, 1, 0, 22'h300, 22'h040, mk_obs(1,1,8'h00,0,1,22'h300,1,16'd3,16'd2,1)));
    tbl.push_back(idle("uf_flush2", mk_obs(0,0,8'h00,0,0,22'h0,1,16'd3,16'd2,1)));
    tbl.push_back(idle("uf_run", mk_obs(0,0,8'h00,0,0,22'h0,0,16'd3,16'd2,1)));
    tbl.push_back(idle("uf_sticky", mk_obs(0,0,8'h00,0,0,22'h0,0,16'd3,16'd2,1)));
    tbl.push_back(mk_vec("push41", 1, 8'h41, 1, 0, 0, 0, 22'h0, 22'h0, mk_obs(0,0,8'h00,0,0,22'h0,0,16'd3,16'd2,1)));
    tbl.push_back(mk_vec("push42", 1, 8'h42, 0, 0, 0, 0, 22'h0, 22'h0, mk_obs(0,0,8'h00,0,0,22'h0,0,16'd3,16'd2,1)));
    tbl.push_back(mk_vec("push43", 1, 8'h43, 1, 0, 0, 0, 22'h0, 22'h0, mk_obs(0,0,8'h00,0,0,22'h0,0,16'd3,16'd2,1)));
    tbl.push_back(mk_vec("beq_mis_ntk", 0, 8'h00, 0, 1, 0, 0, 22'h500, 22'h050, mk_obs(1,0,8'h41,1,1,22'h050,1,16'd4,16'd3,1)));
    tbl.push_back(mk_vec("squash1", 1, 8'h44, 1, 1, 1, 0, 22'h0, 22'h0, mk_obs(0,0,8'h00,0,0,22'h0,1,16'd4,16'd3,1)));
    tbl.push_back(mk_vec("squash2", 0, 8'h00, 0, 1, 1, 0, 22'h0, 22'h0, mk_obs(0,0,8'h00,0,0,22'h0,0,16'd4,16'd3,1)));
    tbl.push_back(mk_vec("after_squash", 0, 8'h00, 0, 1, 0, 0, 22'h600, 22'h060, mk_obs(1,0,8'h00,0,0,22'h0,0,16'd5,16'd3,1)));
    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i]);

    // Full queue: fifth push dropped, push+pop while full keeps FIFO order.
    do_reset("reset_clears_uf");
    apply_vec(mk_vec("full_p1", 1, 8'hA1, 0, 0, 0, 0, 22'h0, 22'h0, '0));
    apply_vec(mk_vec("full_p2", 1, 8'hA2, 0, 0, 0, 0, 22'h0, 22'h0, '0));
    apply_vec(mk_vec("full_p3", 1, 8'hA3, 0, 0, 0, 0, 22'h0, 22'h0, '0));
    apply_vec(mk_vec("full_p4", 1, 8'hA4, 0, 0, 0, 0, 22'h0, 22'h0, '0));
    apply_vec(mk_vec("full_p5_drop", 1, 8'hA5, 0, 0, 0, 0, 22'h0, 22'h0, '0));
    apply_vec(mk_vec("full_pushpop", 1, 8'hA6, 0, 1, 0, 0, 22'h111, 22'h222, mk_obs(1,0,8'hA1,0,0,22'h0,0,16'd1,16'd0,0)));
    apply_vec(mk_vec("full_pop2", 0, 8'h00, 0, 1, 0, 0, 22'h111, 22'h222, mk_obs(1,0,8'hA2,0,0,22'h0,0,16'd2,16'd0,0)));
    apply_vec(mk_vec("full_pop3", 0, 8'h00, 0, 1, 0, 0, 22'h111, 22'h222, mk_obs(1,0,8'hA3,0,0,22'h0,0,16'd3,16'd0,0)));
    apply_vec(mk_vec("full_pop4", 0, 8'h00, 0, 1, 0, 0, 22'h111, 22'h222, mk_obs(1,0,8'hA4,0,0,22'h0,0,16'd4,16'd0,0)));
    apply_vec(mk_vec("full_pop5", 0, 8'h00, 0, 1, 0, 0, 22'h111, 22'h222, mk_obs(1,0,8'hA6,0,0,22'h0,0,16'd5,16'd0,0)));
    apply_vec(mk_vec("full_underflow", 0, 8'h00, 0, 1, 0, 0, 22'h111, 22'h222, mk_obs(1,0,8'h00,0,0,22'h0,0,16'd6,16'd0,1)));

    // Reset in the middle of a flush, then a push on the first free edge.
    apply_vec(mk_vec("rf_push55", 1, 8'h55, 0, 0, 0, 0, 22'h0, 22'h0, mk_obs(0,0,8'h00,0,0,22'h0,0,16'd6,16'd0,1)));
    apply_vec(mk_vec("rf_mis", 0, 8'h00, 0, 1, 1, 0, 22'h1234, 22'h0008, mk_obs(1,1,8'h55,0,1,22'h1234,1,16'd7,16'd1,1)));
    do_reset("reset_in_flush");
    apply_vec(mk_vec("post_rst_push", 1, 8'h66, 1, 0, 0, 0, 22'h0, 22'h0, '0));
    apply_vec(mk_vec("post_rst_pop", 0, 8'h00, 0, 1, 1, 0, 22'h77, 22'h78, mk_obs(1,1,8'h66,1,0,22'h0,0,16'd1,16'd0,0)));

    // Saturation: counters preset just below the limit, then three mispredicts.
    do_reset("reset_sat");
    @(negedge clk);
    rst = 1'b0;
    if_push = 1'b0; ex_branch = 1'b0;
    force dut.r_branch_count = 16'hFFFE;
    force dut.r_mispredict_count = 16'hFFFE;
    #1;
    release dut.r_branch_count;
    release dut.r_mispredict_count;
    for (int k = 0; k < 3; k++) begin
      apply_vec(mk_vec($sformatf("sat_mis%0d", k), 0, 8'h00, 0, 1, 1, 0, 22'h3FFFFF, 22'h1,
                       mk_obs(1,1,8'h00,0,1,22'h3FFFFF,1,16'hFFFF,16'hFFFF,1)));
      if (k < 2) begin
        apply_vec(idle($sformatf("sat_fl%0d", k), mk_obs(0,0,8'h00,0,0,22'h0,1,16'hFFFF,16'hFFFF,1)));
        apply_vec(idle($sformatf("sat_run%0d", k), mk_obs(0,0,8'h00,0,0,22'h0,0,16'hFFFF,16'hFFFF,1)));
      end
    end
    do_reset("reset_sat_flush");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
